// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory access size encodings and the MEM/WB bundle.
// Latency: n/a (types and pure helper function only).
// Backpressure: n/a.
// Contents: mem_size_e (SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD), mem_wb_t, is_aligned().
package mips_pkg;

  // Access size as carried on mem_size; the reserved code behaves as a word.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  // MEM/WB pipeline register contents, consumed by write-back.
  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] alu_result;
    logic [4:0]  reg_dst;
    logic        MemToReg;
    logic        RegWrite;
    logic        misalign;
  } mem_wb_t;

  // Natural alignment check on the low two byte-address bits.
  function automatic logic is_aligned(input mem_size_e size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~lane[0];
      default: return (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the memory stage, bundled as one interface.
// Latency: n/a (wires only).
// Backpressure: stall/flush travel with the bundle; no ready signal back.
// Ports: master drives the EX/MEM side and observes *_q; slave is the memory stage.
interface mem_stage_if;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  reg_dst;
  logic        RegWrite;
  logic        MemToReg;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        stall;
  logic        flush;
  logic [31:0] read_data_q;
  logic [31:0] alu_result_q;
  logic [4:0]  reg_dst_q;
  logic        MemToReg_q;
  logic        RegWrite_q;
  logic        misalign_q;

  modport master (
    output alu_result, write_data, reg_dst, RegWrite, MemToReg, MemRead, MemWrite,
           mem_size, mem_unsigned, stall, flush,
    input  read_data_q, alu_result_q, reg_dst_q, MemToReg_q, RegWrite_q, misalign_q
  );

  modport slave (
    input  alu_result, write_data, reg_dst, RegWrite, MemToReg, MemRead, MemWrite,
           mem_size, mem_unsigned, stall, flush,
    output read_data_q, alu_result_q, reg_dst_q, MemToReg_q, RegWrite_q, misalign_q
  );
endinterface

// File: rtl/mem_stage_data_mem_be.sv
// Word-organised data memory with per-byte write enables and an async read port.
// Latency: write lands at the rising edge; read is combinational from the array.
// Backpressure: none; the caller gates be_i.
// Ports: clk, addr_i (word index), be_i (lane enables), wdata_i (lane-replicated data), rdata_o.
module data_mem_be #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // Not reset: contents are architectural state, not control.
  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Read sees pre-write contents in the store cycle.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: byte/half/word loads and stores, then the MEM/WB register.
// Latency: 1 cycle from EX/MEM inputs to *_q outputs.
// Backpressure: stall holds *_q and blocks stores; flush inserts a bubble and blocks stores.
// Ports: clk, reset (sync, active-high), bus (mem_stage_if.slave: EX/MEM in, MEM/WB out).
module mem_stage
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 8
) (
  input  logic          clk,
  input  logic          reset,
  mem_stage_if.slave    bus
);

  mem_size_e   size;
  logic [1:0]  lane;
  logic        aligned;
  logic        misalign;
  logic        store_en;
  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] rword;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        unused_addr_hi;
  mem_wb_t     wb_d;
  mem_wb_t     wb_q;

  assign size = mem_size_e'(bus.mem_size);
  assign lane = bus.alu_result[1:0];

  // Upper address bits are ignored so out-of-range addresses alias.
  assign unused_addr_hi = ^bus.alu_result[31:ADDR_W+2];

  assign aligned  = is_aligned(size, lane);
  assign misalign = (bus.MemRead | bus.MemWrite) & ~aligned;
  assign store_en = bus.MemWrite & aligned & ~bus.stall & ~bus.flush & ~reset;

  // Store steering: replicate the data across lanes and pick lanes with be.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = bus.write_data;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{bus.write_data[7:0]}};
      end
      SZ_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.write_data[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = bus.write_data;
      end
    endcase
    if (!store_en) begin
      be = 4'b0000;
    end
  end

  data_mem_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .addr_i  (bus.alu_result[ADDR_W+1:2]),
    .be_i    (be),
    .wdata_i (wdata_rep),
    .rdata_o (rword)
  );

  // Load extraction and extension (little-endian lanes).
  always_comb begin
    case (lane)
      2'd0:    ld_byte = rword[7:0];
      2'd1:    ld_byte = rword[15:8];
      2'd2:    ld_byte = rword[23:16];
      default: ld_byte = rword[31:24];
    endcase
    ld_half = lane[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{~bus.mem_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~bus.mem_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = rword;
    endcase
  end

  always_comb begin
    wb_d            = '0;
    wb_d.read_data  = ld_data;
    wb_d.alu_result = bus.alu_result;
    wb_d.reg_dst    = bus.reg_dst;
    wb_d.MemToReg   = bus.MemToReg;
    // A faulting access must not retire into the register file.
    wb_d.RegWrite   = bus.RegWrite & ~misalign;
    wb_d.misalign   = misalign;
  end

  // Priority: reset, flush (bubble), stall (hold), capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_q <= '0;
    end else if (bus.flush) begin
      wb_q <= '0;
    end else if (!bus.stall) begin
      wb_q <= wb_d;
    end
  end

  assign bus.read_data_q  = wb_q.read_data;
  assign bus.alu_result_q = wb_q.alu_result;
  assign bus.reg_dst_q    = wb_q.reg_dst;
  assign bus.MemToReg_q   = wb_q.MemToReg;
  assign bus.RegWrite_q   = wb_q.RegWrite;
  assign bus.misalign_q   = wb_q.misalign;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_stage_if bus();

  mem_stage #(.DEPTH_WORDS(256), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: byte-addressed memory plus the expected MEM/WB contents.
  logic [7:0]  mem_b [1024];
  logic [31:0] e_rd, e_alu;
  logic [4:0]  e_rdst;
  logic        e_m2r, e_rw, e_mis, e_rdchk;

  initial begin
    for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
    total = 0;
    bad   = 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int unsigned a, nb, base;
    logic [31:0] v;
    logic al, acc, mis;
    a    = bus.alu_result;
    nb   = (bus.mem_size == 2'd0) ? 1 : (bus.mem_size == 2'd1) ? 2 : 4;
    al   = (a % nb) == 0;
    acc  = bus.MemRead | bus.MemWrite;
    mis  = acc && !al;
    base = a % 1024;
    v = 32'h0;
    for (int k = 0; k < 4; k++)
      if (k < nb) v = v | (32'(mem_b[(base + k) % 1024]) << (8 * k));
    if (!bus.mem_unsigned && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    if (reset || bus.flush) begin
      e_rd = 0; e_alu = 0; e_rdst = 0; e_m2r = 0; e_rw = 0; e_mis = 0; e_rdchk = 1;
    end else if (!bus.stall) begin
      e_rd    = v;
      e_alu   = bus.alu_result;
      e_rdst  = bus.reg_dst;
      e_m2r   = bus.MemToReg;
      e_rw    = bus.RegWrite && !mis;
      e_mis   = mis;
      e_rdchk = bus.MemRead && al;
    end
    if (bus.MemWrite && al && !bus.stall && !bus.flush && !reset)
      for (int k = 0; k < 4; k++)
        if (k < nb) mem_b[(base + k) % 1024] = bus.write_data[8*k +: 8];
    #1;
    chk("alu_result_q", bus.alu_result_q, e_alu);
    chk("reg_dst_q", 32'(bus.reg_dst_q), 32'(e_rdst));
    chk("MemToReg_q", 32'(bus.MemToReg_q), 32'(e_m2r));
    chk("RegWrite_q", 32'(bus.RegWrite_q), 32'(e_rw));
    chk("misalign_q", 32'(bus.misalign_q), 32'(e_mis));
    if (e_rdchk) chk("read_data_q", bus.read_data_q, e_rd);
  end

  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdst,
                    input logic rw, input logic m2r, input logic st, input logic fl,
                    input logic rst);
    bus.MemRead      = rd;
    bus.MemWrite     = wr;
    bus.mem_size     = sz;
    bus.mem_unsigned = uns;
    bus.alu_result   = addr;
    bus.write_data   = wd;
    bus.reg_dst      = rdst;
    bus.RegWrite     = rw;
    bus.MemToReg     = m2r;
    bus.stall        = st;
    bus.flush        = fl;
    reset            = rst;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
    op(1'b0, 1'b1, sz, 1'b0, addr, wd, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [4:0] rdst);
    op(1'b1, 1'b0, sz, uns, addr, 32'h0, rdst, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset with random inputs for two cycles.
    for (int i = 0; i < 2; i++)
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
         5'($urandom), 1'b1, 1'b1, 1'($urandom), 1'b0, 1'b1);
    chk("rst read_data", bus.read_data_q, 32'h0);
    chk("rst alu_result", bus.alu_result_q, 32'h0);
    chk("rst RegWrite", 32'(bus.RegWrite_q), 32'h0);
    chk("rst MemToReg", 32'(bus.MemToReg_q), 32'h0);
    chk("rst misalign", 32'(bus.misalign_q), 32'h0);

    op(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pass alu_result", bus.alu_result_q, 32'h1234_5678);
    chk("pass reg_dst", 32'(bus.reg_dst_q), 32'd3);
    chk("pass RegWrite", 32'(bus.RegWrite_q), 32'd1);

    // Bring memory to a known all-zero state.
    for (int i = 0; i < 256; i++) store(2'd2, 32'(i * 4), 32'h0);

    store(2'd2, 32'h10, 32'hDEAD_BEEF);
    load(2'd2, 1'b0, 32'h10, 5'd8);
    chk("lw after sw", bus.read_data_q, 32'hDEAD_BEEF);
    chk("lw reg_dst", 32'(bus.reg_dst_q), 32'd8);

    store(2'd0, 32'h13, 32'h0000_0080);
    load(2'd0, 1'b0, 32'h13, 5'd9);
    chk("lb sign", bus.read_data_q, 32'hFFFF_FF80);
    load(2'd0, 1'b1, 32'h13, 5'd9);
    chk("lbu zero", bus.read_data_q, 32'h0000_0080);
    load(2'd2, 1'b0, 32'h10, 5'd9);
    chk("lw merged", bus.read_data_q, 32'h80AD_BEEF);

    store(2'd1, 32'h22, 32'h0000_1234);
    load(2'd1, 1'b0, 32'h22, 5'd10);
    chk("lh", bus.read_data_q, 32'h0000_1234);
    op(1'b0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h0000_ABCD, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("mis flag", 32'(bus.misalign_q), 32'd1);
    chk("mis RegWrite", 32'(bus.RegWrite_q), 32'd0);
    load(2'd2, 1'b0, 32'h20, 5'd10);
    chk("mis flag clears", 32'(bus.misalign_q), 32'd0);
    chk("mis no write", bus.read_data_q, 32'h1234_0000);

    for (int i = 0; i < 3; i++) begin
      op(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'h55, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("stall hold alu", bus.alu_result_q, 32'h20);
      chk("stall hold rd", bus.read_data_q, 32'h1234_0000);
    end
    store(2'd2, 32'h40, 32'h55);
    chk("stall release", bus.alu_result_q, 32'h40);
    load(2'd2, 1'b0, 32'h40, 5'd2);
    chk("store after stall", bus.read_data_q, 32'h55);

    op(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("flush RegWrite", 32'(bus.RegWrite_q), 32'd0);
    chk("flush MemToReg", 32'(bus.MemToReg_q), 32'd0);

    op(1'b0, 1'b1, 2'd2, 1'b0, 32'h44, 32'h77, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst mid-stall", bus.alu_result_q, 32'h0);
    load(2'd2, 1'b0, 32'h44, 5'd2);
    chk("rst drops store", bus.read_data_q, 32'h0);

    store(2'd2, 32'h400, 32'hCAFE_F00D);
    load(2'd2, 1'b0, 32'h0, 5'd5);
    chk("wrap alias", bus.read_data_q, 32'hCAFE_F00D);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] addr;
      addr = $urandom_range(0, 127);
      if ($urandom_range(0, 9) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
      op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), addr, $urandom,
         5'($urandom), 1'($urandom), 1'($urandom),
         $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2);
    end

    op(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access stage of the 5-stage MIPS pipeline, directly upstream of the write-back stage. It takes the EX/MEM bundle, performs loads and stores against an internal word-organised data memory with byte/half/word lanes, and registers the results into the MEM/WB pipeline register. Its registered outputs feed write-back, which selects between read_data and alu_result.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the data memory
ADDR_W, 8, word-index width; equals log2(DEPTH_WORDS)

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
alu_result  in  32  byte address for loads/stores; pass-through result otherwise
write_data  in  32  store data (rt value)
reg_dst  in  5  destination register
RegWrite  in  1  destination write enable
MemToReg  in  1  write-back selects memory data
MemRead  in  1  load request
MemWrite  in  1  store request
mem_size  in  2  00 = byte, 01 = half, 10 = word; 11 is reserved and treated as word
mem_unsigned  in  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
stall  in  1  hold MEM/WB register, block store
flush  in  1  insert bubble into MEM/WB register, block store
read_data_q  out  32  registered, extended load data
alu_result_q  out  32  registered alu_result
reg_dst_q  out  5  registered reg_dst
MemToReg_q  out  1  registered MemToReg
RegWrite_q  out  1  registered RegWrite, forced 0 on bubble or misalign
misalign_q  out  1  one-cycle registered flag: the access in the register was misaligned

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high. On reset, all *_q outputs are 0. Memory contents are not reset; simulation initialises them to 0.
- Word index: alu_result[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses wrap. Byte lane: alu_result[1:0], little-endian (lane 0 = bits 7:0).
- Alignment rule: half requires addr[0] = 0; word requires addr[1:0] = 0. Misaligned accesses (with MemRead or MemWrite set):
  - no memory write;
  - RegWrite_q = 0;
  - misalign_q = 1 for exactly one cycle.
  Alignment is ignored when neither MemRead nor MemWrite is set.
- Store, effective enable = MemWrite & aligned & ~stall & ~flush & ~reset:
  - written at the rising edge, using byte enables;
  - byte: write_data[7:0] goes to the addressed lane;
  - half: write_data[15:0] goes to lanes {addr[1],0} and {addr[1],1};
  - word: all four lanes;
  - untouched lanes are preserved.
- Load: the memory array is read combinationally in the same cycle. The selected lane(s) are extended per mem_size/mem_unsigned and registered into read_data_q. Load-to-output latency is 1 cycle. With MemRead = 0, read_data_q is still updated from the array (don't-care, but deterministic).
- Store then load to the same word in the next cycle: the load returns the newly stored data.
- MemRead & MemWrite together: the store is performed; read_data_q captures the pre-store contents.
- Register update each edge, in priority order:
  1. reset: clear all outputs;
  2. flush: bubble, i.e. RegWrite_q = 0, MemToReg_q = 0, misalign_q = 0, other outputs 0;
  3. stall: hold all outputs;
  4. otherwise: capture the inputs.
- flush has priority over stall.
- reset mid-stall: outputs clear, and any pending store is dropped.

Decomposition:
- Shared package, mips_pkg:
  - size encodings: SZ_BYTE, SZ_HALF, SZ_WORD;
  - the MEM/WB bundle struct: read_data, alu_result, reg_dst, MemToReg, RegWrite, misalign.
- One sub-module, data_mem_be: a DEPTH_WORDS x 32 array with 4-bit byte-enable synchronous write and an asynchronous read port.
- Lane steering, extension and the alignment check stay in mem_stage.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all *_q = 0; release -> outputs track inputs after 1 cycle.
- sw 0xDEADBEEF to addr 0x10, then next cycle lw addr 0x10 (MemToReg = 1, RegWrite = 1, reg_dst = 8) -> read_data_q = 0xDEADBEEF, reg_dst_q = 8 one cycle after the load.
- sb 0x80 to addr 0x13, then lb 0x13 -> read_data_q = 0xFFFFFF80; lbu 0x13 -> 0x00000080; lw 0x10 -> 0x80ADBEEF.
- sh 0x1234 to addr 0x22, then lh 0x22 -> 0x00001234; sh to addr 0x21 -> misalign_q = 1 for 1 cycle, RegWrite_q = 0, and a following lw 0x20 shows memory unchanged.
- stall = 1 for 3 cycles with sw 0x55 to 0x40 presented -> outputs hold and the memory word is unchanged; on release the store completes once.
- flush and stall both high with lw, RegWrite = 1 -> RegWrite_q = 0, MemToReg_q = 0 next cycle.
- Address 0x400 (wraps to index 0) with DEPTH_WORDS = 256 -> aliases word 0.
